// File: rtl/lsu_ctrl_if.sv
// Request, data-memory and response bundle of the load/store unit controller.
// slave is the controller side; master is the pipeline/memory environment side.
interface lsu_ctrl_if #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic [2:0]            req_op;
    logic                  req_we;
    logic [31:0]           req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [4:0]            req_rd;

    logic [2:0]            mem_op;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_rdata;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic [4:0]            rsp_rd;
    logic                  rsp_is_load;
    logic                  rsp_misalign;

    modport slave (
        input  req_valid, req_op, req_we, req_addr, req_wdata, req_rd, mem_rdata, rsp_ready,
        output req_ready, mem_op, mem_addr, mem_wdata, mem_we,
        output rsp_valid, rsp_data, rsp_rd, rsp_is_load, rsp_misalign
    );

    modport master (
        output req_valid, req_op, req_we, req_addr, req_wdata, req_rd, mem_rdata, rsp_ready,
        input  req_ready, mem_op, mem_addr, mem_wdata, mem_we,
        input  rsp_valid, rsp_data, rsp_rd, rsp_is_load, rsp_misalign
    );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: runs one request at a time through the data memory and returns a
// WB response. Define LSU_MISALIGN_TRAP_EN to trap misaligned halfword/word accesses.
module lsu_ctrl #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 32
) (
    input logic       clk,
    input logic       rst,
    lsu_ctrl_if.slave lsu_io
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ACCESS  = 2'd1;
    localparam logic [1:0] CAPTURE = 2'd2;
    localparam logic [1:0] RESP    = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [2:0]            op_q;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [4:0]            rd_q;

    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [4:0]            rsp_rd_q, rsp_rd_d;
    logic                  rsp_is_load_q, rsp_is_load_d;
    logic                  rsp_misalign_q, rsp_misalign_d;

    logic                  req_ready;
    logic                  accept;
    logic                  misalign;
    logic                  unused_addr_hi;

    assign unused_addr_hi = ^lsu_io.req_addr[31:ADDR_WIDTH];

    assign req_ready = (state_q == IDLE) || ((state_q == RESP) && lsu_io.rsp_ready);
    assign accept    = lsu_io.req_valid && req_ready;

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign = ((lsu_io.req_op[1:0] == 2'b01) && lsu_io.req_addr[0]) ||
                      ((lsu_io.req_op[1:0] == 2'b10) && (lsu_io.req_addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    always_comb begin
        state_d        = state_q;
        rsp_data_d     = rsp_data_q;
        rsp_rd_d       = rsp_rd_q;
        rsp_is_load_d  = rsp_is_load_q;
        rsp_misalign_d = rsp_misalign_q;
        unique case (state_q)
            IDLE, RESP: begin
                if (accept) begin
                    // A trapped access skips the memory and answers on the next edge.
                    if (misalign) begin
                        state_d        = RESP;
                        rsp_data_d     = '0;
                        rsp_rd_d       = lsu_io.req_we ? 5'd0 : lsu_io.req_rd;
                        rsp_is_load_d  = !lsu_io.req_we;
                        rsp_misalign_d = 1'b1;
                    end else begin
                        state_d = ACCESS;
                    end
                end else if (state_q == RESP && lsu_io.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                if (we_q) begin
                    state_d        = RESP;
                    rsp_data_d     = '0;
                    rsp_rd_d       = 5'd0;
                    rsp_is_load_d  = 1'b0;
                    rsp_misalign_d = 1'b0;
                end else begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                state_d        = RESP;
                rsp_data_d     = lsu_io.mem_rdata;
                rsp_rd_d       = rd_q;
                rsp_is_load_d  = 1'b1;
                rsp_misalign_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            op_q           <= '0;
            we_q           <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            rd_q           <= '0;
            rsp_data_q     <= '0;
            rsp_rd_q       <= '0;
            rsp_is_load_q  <= 1'b0;
            rsp_misalign_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            rsp_data_q     <= rsp_data_d;
            rsp_rd_q       <= rsp_rd_d;
            rsp_is_load_q  <= rsp_is_load_d;
            rsp_misalign_q <= rsp_misalign_d;
            if (accept) begin
                op_q    <= lsu_io.req_op;
                we_q    <= lsu_io.req_we;
                addr_q  <= lsu_io.req_addr[ADDR_WIDTH-1:0];
                wdata_q <= lsu_io.req_wdata;
                rd_q    <= lsu_io.req_rd;
            end
        end
    end

    assign lsu_io.req_ready    = req_ready;
    assign lsu_io.mem_op       = op_q;
    assign lsu_io.mem_addr     = addr_q;
    assign lsu_io.mem_wdata    = wdata_q;
    assign lsu_io.mem_we       = (state_q == ACCESS) && we_q;
    assign lsu_io.rsp_valid    = (state_q == RESP);
    assign lsu_io.rsp_data     = rsp_data_q;
    assign lsu_io.rsp_rd       = rsp_rd_q;
    assign lsu_io.rsp_is_load  = rsp_is_load_q;
    assign lsu_io.rsp_misalign = rsp_misalign_q;
endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: directed vector table, corner sequences, and random traffic checked by a
// transaction-level model with its own shadow memory.
module tb_lsu_ctrl;
    localparam int AW    = 15;
    localparam int DW    = 32;
    localparam int MEMSZ = 1 << AW;
`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    lsu_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
    lsu_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (.clk(clk), .rst(rst), .lsu_io(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] dmem [MEMSZ];
    logic [7:0] rmem [MEMSZ];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int nbytes(input logic [2:0] op);
        return (op[1:0] == 2'b00) ? 1 : (op[1:0] == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ext(input logic [2:0] op, input logic [31:0] w);
        case (op)
            3'b000:  return {{24{w[7]}}, w[7:0]};
            3'b001:  return {{16{w[15]}}, w[15:0]};
            3'b100:  return {24'h0, w[7:0]};
            3'b101:  return {16'h0, w[15:0]};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] rword(input logic [AW-1:0] a, input bit shadow);
        logic [31:0] w;
        for (int i = 0; i < 4; i++)
            w[8*i +: 8] = shadow ? rmem[a + AW'(i)] : dmem[a + AW'(i)];
        return w;
    endfunction

    // Data memory unit: byte-lane writes, extended read data one cycle after the address.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MEMSZ; i++) dmem[i] <= 8'h0;
        end else if (bus.mem_we) begin
            for (int i = 0; i < 4; i++)
                if (i < nbytes(bus.mem_op)) dmem[bus.mem_addr + AW'(i)] <= bus.mem_wdata[8*i +: 8];
        end
        bus.mem_rdata <= ext(bus.mem_op, rword(bus.mem_addr, 1'b0));
    end

    // Transaction model: one outstanding request, timed by the edge it was accepted on.
    bit          m_pend = 1'b0;
    int          m_e, m_lat;
    logic        m_we, m_trap, m_ld;
    logic [2:0]  m_op;
    logic [AW-1:0] m_addr;
    logic [31:0] m_wdata, m_data;
    logic [4:0]  m_rd;

    always @(negedge clk) begin
        bit ev, er;
        if (rst) begin
            m_pend = 1'b0;
            for (int i = 0; i < MEMSZ; i++) rmem[i] = 8'h0;
            chk("rst_mem_we", {31'h0, bus.mem_we}, 32'h0);
            chk("rst_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
        end else begin
            if (m_pend && !m_trap && cyc == m_e) begin
                chk("mem_addr", {17'h0, bus.mem_addr}, {17'h0, m_addr});
                chk("mem_op", {29'h0, bus.mem_op}, {29'h0, m_op});
                if (m_we) begin
                    chk("mem_wdata", bus.mem_wdata, m_wdata);
                    for (int i = 0; i < nbytes(m_op); i++) rmem[m_addr + AW'(i)] = m_wdata[8*i +: 8];
                end else begin
                    m_data = ext(m_op, rword(m_addr, 1'b1));
                end
            end
            ev = m_pend && (cyc >= m_e + m_lat - 1);
            chk("rsp_valid", {31'h0, bus.rsp_valid}, {31'h0, ev});
            if (ev) begin
                chk("rsp_data", bus.rsp_data, m_data);
                chk("rsp_rd", {27'h0, bus.rsp_rd}, {27'h0, m_rd});
                chk("rsp_is_load", {31'h0, bus.rsp_is_load}, {31'h0, m_ld});
                chk("rsp_misalign", {31'h0, bus.rsp_misalign}, {31'h0, m_trap});
            end
            chk("mem_we", {31'h0, bus.mem_we},
                {31'h0, m_pend && !m_trap && m_we && cyc == m_e});
            er = !m_pend || (ev && bus.rsp_ready);
            chk("req_ready", {31'h0, bus.req_ready}, {31'h0, er});
            if (ev && bus.rsp_ready) m_pend = 1'b0;
            if (bus.req_valid && er) begin
                m_pend  = 1'b1;
                m_e     = cyc + 1;
                m_op    = bus.req_op;
                m_we    = bus.req_we;
                m_addr  = bus.req_addr[AW-1:0];
                m_wdata = bus.req_wdata;
                m_ld    = !bus.req_we;
                m_rd    = bus.req_we ? 5'd0 : bus.req_rd;
                m_trap  = TRAP && (((bus.req_op[1:0] == 2'b01) && bus.req_addr[0]) ||
                                   ((bus.req_op[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00)));
                m_lat   = m_trap ? 1 : (bus.req_we ? 2 : 3);
                m_data  = 32'h0;
            end
        end
    end

    typedef struct {
        logic [2:0]  op;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic [31:0] d;
        logic [4:0]  erd;
        logic        ld;
        logic        mis;
        int          lat;
    } vec_t;

    vec_t vt [13];

    task automatic drive(input logic [2:0] op, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] rd);
        bus.req_op    = op;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_rd    = rd;
        bus.req_valid = 1'b1;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int  e, n_we;
        bit  seen;
        @(posedge clk); #1;
        drive(v.op, v.we, v.addr, v.wdata, v.rd);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk($sformatf("v%0d_ready", idx), {31'h0, bus.req_ready}, 32'h1);
        e    = cyc + 1;
        n_we = 0;
        seen = 1'b0;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        for (int k = 0; k < 8 && !seen; k++) begin
            @(negedge clk);
            if (bus.mem_we) n_we++;
            if (bus.rsp_valid) begin
                seen = 1'b1;
                chk($sformatf("v%0d_lat", idx), cyc - e + 1, v.lat);
                chk($sformatf("v%0d_data", idx), bus.rsp_data, v.d);
                chk($sformatf("v%0d_rd", idx), {27'h0, bus.rsp_rd}, {27'h0, v.erd});
                chk($sformatf("v%0d_ld", idx), {31'h0, bus.rsp_is_load}, {31'h0, v.ld});
                chk($sformatf("v%0d_mis", idx), {31'h0, bus.rsp_misalign}, {31'h0, v.mis});
            end
        end
        chk($sformatf("v%0d_seen", idx), {31'h0, seen}, 32'h1);
        chk($sformatf("v%0d_we_cycles", idx), n_we, (v.we && !v.mis) ? 1 : 0);
    endtask

    initial begin
        bit hs, seen;
        int e;
        int opsel;

        vt[0]  = '{3'b010, 1'b1, 32'h10, 32'hDEADBEEF, 5'd7, 32'h0, 5'd0, 1'b0, 1'b0, 2};
        vt[1]  = '{3'b010, 1'b0, 32'h10, 32'h0, 5'd5, 32'hDEADBEEF, 5'd5, 1'b1, 1'b0, 3};
        vt[2]  = '{3'b000, 1'b0, 32'h13, 32'h0, 5'd1, 32'hFFFFFFDE, 5'd1, 1'b1, 1'b0, 3};
        vt[3]  = '{3'b100, 1'b0, 32'h13, 32'h0, 5'd2, 32'h000000DE, 5'd2, 1'b1, 1'b0, 3};
        vt[4]  = '{3'b001, 1'b0, 32'h12, 32'h0, 5'd3, 32'hFFFFDEAD, 5'd3, 1'b1, 1'b0, 3};
        vt[5]  = '{3'b101, 1'b0, 32'h12, 32'h0, 5'd4, 32'h0000DEAD, 5'd4, 1'b1, 1'b0, 3};
        vt[6]  = '{3'b000, 1'b1, 32'h20, 32'h12345680, 5'd9, 32'h0, 5'd0, 1'b0, 1'b0, 2};
        vt[7]  = '{3'b000, 1'b0, 32'h20, 32'h0, 5'd9, 32'hFFFFFF80, 5'd9, 1'b1, 1'b0, 3};
        vt[8]  = '{3'b001, 1'b1, 32'h22, 32'hAAAA7F01, 5'd0, 32'h0, 5'd0, 1'b0, 1'b0, 2};
        vt[9]  = '{3'b010, 1'b0, 32'h20, 32'h0, 5'd31, 32'h7F010080, 5'd31, 1'b1, 1'b0, 3};
        vt[10] = '{3'b010, 1'b0, 32'hFFFF8010, 32'h0, 5'd6, 32'hDEADBEEF, 5'd6, 1'b1, 1'b0, 3};
`ifdef LSU_MISALIGN_TRAP_EN
        vt[11] = '{3'b001, 1'b0, 32'h11, 32'h0, 5'd8, 32'h0, 5'd8, 1'b1, 1'b1, 1};
        vt[12] = '{3'b010, 1'b1, 32'h16, 32'h11223344, 5'd0, 32'h0, 5'd0, 1'b0, 1'b1, 1};
`else
        vt[11] = '{3'b001, 1'b0, 32'h11, 32'h0, 5'd8, 32'hFFFFADBE, 5'd8, 1'b1, 1'b0, 3};
        vt[12] = '{3'b010, 1'b1, 32'h16, 32'h11223344, 5'd0, 32'h0, 5'd0, 1'b0, 1'b0, 2};
`endif

        bus.req_valid = 1'b0;
        bus.req_op    = 3'b000;
        bus.req_we    = 1'b0;
        bus.req_addr  = 32'h0;
        bus.req_wdata = 32'h0;
        bus.req_rd    = 5'd0;
        bus.rsp_ready = 1'b1;

        repeat (2) @(negedge clk);
        chk("rst_rsp_data", bus.rsp_data, 32'h0);
        chk("rst_rsp_rd", {27'h0, bus.rsp_rd}, 32'h0);
        chk("rst_rsp_is_load", {31'h0, bus.rsp_is_load}, 32'h0);
        chk("rst_rsp_misalign", {31'h0, bus.rsp_misalign}, 32'h0);
        chk("rst_mem_op", {29'h0, bus.mem_op}, 32'h0);
        chk("rst_mem_addr", {17'h0, bus.mem_addr}, 32'h0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_req_ready", {31'h0, bus.req_ready}, 32'h1);

        for (int i = 0; i < 13; i++) run_vec(i, vt[i]);

        // Stalled load response, with the next request held until the handshake edge.
        @(posedge clk); #1;
        drive(3'b000, 1'b0, 32'h13, 32'h0, 5'd10);
        bus.rsp_ready = 1'b0;
        @(posedge clk); #1;
        drive(3'b010, 1'b0, 32'h10, 32'h0, 5'd5);
        seen = 1'b0;
        for (int k = 0; k < 8 && !seen; k++) begin
            @(negedge clk);
            seen = bus.rsp_valid;
        end
        chk("stall_seen", {31'h0, seen}, 32'h1);
        for (int k = 0; k < 4; k++) begin
            chk("stall_valid", {31'h0, bus.rsp_valid}, 32'h1);
            chk("stall_data", bus.rsp_data, 32'hFFFFFFDE);
            chk("stall_rd", {27'h0, bus.rsp_rd}, 32'd10);
            chk("stall_ld", {31'h0, bus.rsp_is_load}, 32'h1);
            chk("stall_ready", {31'h0, bus.req_ready}, 32'h0);
            @(posedge clk); #1;
            if (k == 3) bus.rsp_ready = 1'b1;
            @(negedge clk);
        end
        chk("b2b_ready", {31'h0, bus.req_ready}, 32'h1);
        e = cyc + 1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 8 && !seen; k++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                seen = 1'b1;
                chk("b2b_lat", cyc - e + 1, 3);
                chk("b2b_data", bus.rsp_data, 32'hDEADBEEF);
                chk("b2b_rd", {27'h0, bus.rsp_rd}, 32'd5);
            end
        end
        chk("b2b_seen", {31'h0, seen}, 32'h1);

        // Reset in the middle of a store's memory cycle.
        @(posedge clk); #1;
        drive(3'b010, 1'b1, 32'h30, 32'hCAFEF00D, 5'd0);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk("rst_mid_we_before", {31'h0, bus.mem_we}, 32'h1);
        #1 rst = 1'b1;
        #1;
        chk("rst_mid_we_after", {31'h0, bus.mem_we}, 32'h0);
        chk("rst_mid_valid", {31'h0, bus.rsp_valid}, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rst_mid_ready", {31'h0, bus.req_ready}, 32'h1);
            chk("rst_mid_norsp", {31'h0, bus.rsp_valid}, 32'h0);
        end

        // Random traffic; the model checks every cycle.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            hs = bus.req_valid && bus.req_ready;
            @(posedge clk); #1;
            if (hs || !bus.req_valid) begin
                if ($urandom_range(0, 2) != 0) begin
                    bus.req_we = $urandom_range(0, 1) == 1;
                    opsel = bus.req_we ? $urandom_range(0, 2) : $urandom_range(0, 4);
                    drive((opsel < 3) ? 3'(opsel) : 3'(opsel + 1), bus.req_we,
                          ($urandom() & 32'hFFFF8000) | 32'($urandom_range(0, 63)),
                          $urandom(), 5'($urandom_range(0, 31)));
                end else begin
                    bus.req_valid = 1'b0;
                end
            end
            bus.rsp_ready = $urandom_range(0, 3) != 0;
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        repeat (6) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 15, data-memory byte-address width driven to the data memory unit.
REQ-002 Parameter DATA_WIDTH, default 32, data-path width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 req_valid  in  1  EX-stage memory request valid.
REQ-006 req_ready  out  1  request accepted on an edge where req_valid and req_ready are both high.
REQ-007 req_op  in  3  funct3: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
REQ-008 req_we  in  1  1=store, 0=load.
REQ-009 req_addr  in  32  byte address.
REQ-010 req_wdata  in  DATA_WIDTH  store data.
REQ-011 req_rd  in  5  load destination register.
REQ-012 mem_op / mem_addr / mem_wdata / mem_we  out  3 / ADDR_WIDTH / DATA_WIDTH / 1  to the data memory unit op/addr/data_in/we.
REQ-013 mem_rdata  in  DATA_WIDTH  from the data memory unit data_out; already extended; valid one cycle after the address is presented.
REQ-014 rsp_valid  out  1; rsp_ready  in  1  response handshake toward WB.
REQ-015 rsp_data  out  DATA_WIDTH; rsp_rd  out  5; rsp_is_load  out  1; rsp_misalign  out  1.

Function
REQ-016 FSM states IDLE, ACCESS, CAPTURE, RESP; state registered.
REQ-017 req_ready SHALL be 1 in IDLE, and in RESP when rsp_ready=1; 0 otherwise.
REQ-018 On accept, op, we, addr[ADDR_WIDTH-1:0], wdata, and rd SHALL be registered; next state ACCESS; upper addr bits are discarded.
REQ-019 mem_op/mem_addr/mem_wdata SHALL reflect the registered request in every state; mem_we SHALL be 1 only in ACCESS of a store (exactly one cycle per store).
REQ-020 ACCESS -> CAPTURE for loads, ACCESS -> RESP for stores.
REQ-021 CAPTURE SHALL register mem_rdata into rsp_data verbatim (no further extension); next state RESP.
REQ-022 RESP SHALL hold rsp_valid=1 and all rsp_* stable until rsp_ready=1.
REQ-023 RESP with rsp_ready=1 SHALL go to ACCESS if req_valid=1 (back-to-back accept), else IDLE.
REQ-024 Load latency SHALL be 3 edges from accept edge to rsp_valid high; store latency SHALL be 2 edges.
REQ-025 Stores SHALL return rsp_is_load=0, rsp_data=0, and rsp_rd=0; loads SHALL return rsp_is_load=1 and rsp_rd=captured rd.
REQ-026 req_valid with req_ready=0 SHALL be ignored; the requester holds it.

Reset
REQ-027 rst=1 SHALL asynchronously force IDLE; mem_we=0 immediately, including mid-ACCESS.
REQ-028 Reset values SHALL be: rsp_valid=0, rsp_data=0, rsp_rd=0, rsp_is_load=0, rsp_misalign=0, mem_op=0, mem_addr=0, mem_wdata=0, mem_we=0, and req_ready=1 after release.
REQ-029 A request in flight at reset SHALL be dropped with no response.

Configuration
REQ-030 Macro LSU_MISALIGN_TRAP_EN.
REQ-031 Defined: a halfword with addr[0]!=0, or a word with addr[1:0]!=0, SHALL go IDLE/RESP -> RESP directly with no memory access (mem_we stays 0), rsp_misalign=1, rsp_data=0, and latency 1 edge.
REQ-032 Undefined: no check; rsp_misalign SHALL be tied 0; misaligned requests proceed normally with the raw address.

Verification
REQ-033 Reset release; SW op=010 addr=0x10 wdata=0xDEADBEEF -> mem_we high exactly 1 cycle with mem_addr=0x10; rsp_valid 2 edges later; rsp_is_load=0.
REQ-034 LW addr=0x10 rd=5 after REQ-033 (memory model returns 0xDEADBEEF) -> rsp_valid 3 edges after accept, rsp_data=0xDEADBEEF, rsp_rd=5.
REQ-035 LB addr=0x13 with rsp_ready held 0 for 4 cycles -> rsp_* stable 4 cycles, req_ready=0; then rsp_ready=1 with req_valid=1 -> next request accepted the same edge.
REQ-036 LH addr=0x11 -> with LSU_MISALIGN_TRAP_EN: rsp_misalign=1 after 1 edge, no mem access; without: normal load, rsp_misalign=0.
REQ-037 rst asserted during ACCESS of SW -> mem_we drops asynchronously, no response, req_ready=1 after release.
